// File: rtl/carfield_region_map_ctrl.sv
// rtl/carfield_region_map_ctrl.sv - runtime-programmable address region map with checked shadow->active commit
// Optional miss logging (MISS_CNT / MISS_ADDR_LO / MISS_ADDR_HI): define CARFIELD_REGION_MAP_MISS_LOG_EN.
module carfield_region_map_ctrl #(
  parameter int unsigned NumRules   = 8,
  parameter int unsigned NumSlv     = 7,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DefaultIdx = 0,
  parameter logic [NumRules-1:0][AddrWidth-1:0] InitStart = '0,
  parameter logic [NumRules-1:0][AddrWidth-1:0] InitEnd   = '0,
  parameter logic [NumRules-1:0][7:0]           InitIdx   = '0,
  parameter logic [NumRules-1:0]                InitEn    = '0,
  localparam int unsigned SlvIdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [8:0]           reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  output logic                 reg_rvalid_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_error_o,
  input  logic                 dec_valid_i,
  input  logic [AddrWidth-1:0] dec_addr_i,
  output logic                 dec_valid_o,
  output logic [SlvIdxW-1:0]   dec_idx_o,
  output logic                 dec_err_o,
  output logic                 cfg_busy_o
);

  localparam int unsigned RuleW  = $clog2(NumRules);
  localparam int unsigned HiW    = AddrWidth - 32;
  localparam int unsigned EndHiW = (HiW > 16) ? 16 : HiW;

  localparam logic [8:0] AddrCtrl   = 9'h100;
  localparam logic [8:0] AddrStatus = 9'h104;
`ifdef CARFIELD_REGION_MAP_MISS_LOG_EN
  localparam logic [8:0] AddrMissCnt = 9'h108;
  localparam logic [8:0] AddrMissLo  = 9'h10C;
  localparam logic [8:0] AddrMissHi  = 9'h110;
`endif

  typedef enum logic [1:0] {StIdle, StCheck, StApply, StFail} state_e;

  state_e state, stateNext;

  logic [AddrWidth-1:0] shBase  [NumRules];
  logic [AddrWidth-1:0] shEnd   [NumRules];
  logic [SlvIdxW-1:0]   shIdx   [NumRules];
  logic [NumRules-1:0]  shEn;
  logic [AddrWidth-1:0] actBase [NumRules];
  logic [AddrWidth-1:0] actEnd  [NumRules];
  logic [SlvIdxW-1:0]   actIdx  [NumRules];
  logic [NumRules-1:0]  actEn;

  logic             locked, overlapErr, emptyErr, busy;
  logic [RuleW-1:0] pairI, pairJ, errI, errJ;
  logic             startCheck, advance, recErr, doApply;
  logic             pairOverlap, pairEmpty, pairBad, lastPair;

  logic [3:0]       ruleSel;
  logic [1:0]       fieldSel;
  logic [RuleW-1:0] ruleIdx;
  logic             isRule, isCtrl, isStatus, rdMapped, wrRo, idxBad, regErrNext;
  logic             wrAcc, commitReq;
  logic [31:0]      rdWord;
  logic [HiW-1:0]   endHiBits;

  logic               hit;
  logic [SlvIdxW-1:0] hitIdx;

`ifdef CARFIELD_REGION_MAP_MISS_LOG_EN
  logic [31:0]          missCnt;
  logic [AddrWidth-1:0] missAddr;
`endif

  assign busy       = (state == StCheck);
  assign cfg_busy_o = busy;

  // Register address decode
  assign ruleSel  = reg_addr_i[7:4];
  assign fieldSel = reg_addr_i[3:2];
  assign ruleIdx  = ruleSel[RuleW-1:0];
  assign isRule   = !reg_addr_i[8] && (32'(ruleSel) < NumRules) && (reg_addr_i[1:0] == 2'b00);
  assign isCtrl   = (reg_addr_i == AddrCtrl);
  assign isStatus = (reg_addr_i == AddrStatus);

  always_comb begin
    rdMapped = 1'b0;
    rdWord   = '0;
    wrRo     = isStatus;
    if (isRule) begin
      rdMapped = 1'b1;
      case (fieldSel)
        2'd0: rdWord = shBase[ruleIdx][31:0];
        2'd1: rdWord = 32'(shBase[ruleIdx][AddrWidth-1:32]);
        2'd2: rdWord = shEnd[ruleIdx][31:0];
        default: begin
          rdWord[8 +: EndHiW]     = shEnd[ruleIdx][32 +: EndHiW];
          rdWord[SlvIdxW-1:0]     = shIdx[ruleIdx];
          rdWord[31]              = shEn[ruleIdx];
        end
      endcase
    end else if (isCtrl) begin
      rdMapped  = 1'b1;
      rdWord[1] = locked;
    end else if (isStatus) begin
      rdMapped = 1'b1;
      rdWord   = {16'h0, 4'(errJ), 4'(errI), 4'h0, locked, emptyErr, overlapErr, busy};
`ifdef CARFIELD_REGION_MAP_MISS_LOG_EN
    end else if (reg_addr_i == AddrMissCnt) begin
      rdMapped = 1'b1;
      rdWord   = missCnt;
    end else if (reg_addr_i == AddrMissLo) begin
      rdMapped = 1'b1;
      wrRo     = 1'b1;
      rdWord   = missAddr[31:0];
    end else if (reg_addr_i == AddrMissHi) begin
      rdMapped = 1'b1;
      wrRo     = 1'b1;
      rdWord   = 32'(missAddr[AddrWidth-1:32]);
`endif
    end
  end

  assign idxBad     = isRule && (fieldSel == 2'd3) && (32'(reg_wdata_i[7:0]) >= NumSlv);
  assign regErrNext = !rdMapped || (reg_write_i && (busy || locked || wrRo || idxBad));
  assign wrAcc      = reg_valid_i && reg_write_i && !regErrNext;
  assign commitReq  = wrAcc && isCtrl && reg_wdata_i[0];

  // END_HI keeps the address bits above the idx byte; anything beyond 16 bits reads as zero
  always_comb begin
    endHiBits                = '0;
    endHiBits[EndHiW-1:0]    = reg_wdata_i[8 +: EndHiW];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_error_o  <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_valid_i;
      reg_error_o  <= reg_valid_i && regErrNext;
      reg_rdata_o  <= (reg_valid_i && !reg_write_i && !regErrNext) ? rdWord : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NumRules; r++) begin
        shBase[r] <= InitStart[r];
        shEnd[r]  <= InitEnd[r];
        shIdx[r]  <= SlvIdxW'(InitIdx[r]);
      end
      shEn <= InitEn;
    end else if (wrAcc && isRule) begin
      case (fieldSel)
        2'd0: shBase[ruleIdx][31:0]          <= reg_wdata_i;
        2'd1: shBase[ruleIdx][AddrWidth-1:32] <= reg_wdata_i[HiW-1:0];
        2'd2: shEnd[ruleIdx][31:0]           <= reg_wdata_i;
        default: begin
          shEnd[ruleIdx][AddrWidth-1:32] <= endHiBits;
          shIdx[ruleIdx]                 <= reg_wdata_i[SlvIdxW-1:0];
          shEn[ruleIdx]                  <= reg_wdata_i[31];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NumRules; r++) begin
        actBase[r] <= InitStart[r];
        actEnd[r]  <= InitEnd[r];
        actIdx[r]  <= SlvIdxW'(InitIdx[r]);
      end
      actEn <= InitEn;
    end else if (doApply) begin
      actBase <= shBase;
      actEnd  <= shEnd;
      actIdx  <= shIdx;
      actEn   <= shEn;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked <= 1'b0;
    end else if (wrAcc && isCtrl && reg_wdata_i[1]) begin
      locked <= 1'b1;
    end
  end

  // One shadow rule pair per cycle; disabled rules never flag
  assign pairOverlap = shEn[pairI] && shEn[pairJ] &&
                       (shBase[pairI] < shEnd[pairJ]) && (shBase[pairJ] < shEnd[pairI]);
  assign pairEmpty   = (shEn[pairI] && (shEnd[pairI] <= shBase[pairI])) ||
                       (shEn[pairJ] && (shEnd[pairJ] <= shBase[pairJ]));
  assign pairBad     = pairOverlap || pairEmpty;
  assign lastPair    = (pairI == RuleW'(NumRules - 2)) && (pairJ == RuleW'(NumRules - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    startCheck = 1'b0;
    advance    = 1'b0;
    recErr     = 1'b0;
    doApply    = 1'b0;
    case (state)
      StCheck: begin
        if (pairBad) begin
          stateNext = StFail;
          recErr    = 1'b1;
        end else if (lastPair) begin
          stateNext = StApply;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        doApply = (state == StApply);
        if (commitReq) begin
          stateNext  = StCheck;
          startCheck = 1'b1;
        end else begin
          stateNext = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pairI      <= '0;
      pairJ      <= RuleW'(1);
      errI       <= '0;
      errJ       <= '0;
      overlapErr <= 1'b0;
      emptyErr   <= 1'b0;
    end else if (startCheck) begin
      pairI      <= '0;
      pairJ      <= RuleW'(1);
      errI       <= '0;
      errJ       <= '0;
      overlapErr <= 1'b0;
      emptyErr   <= 1'b0;
    end else if (recErr) begin
      errI       <= pairI;
      errJ       <= pairJ;
      overlapErr <= pairOverlap;
      emptyErr   <= pairEmpty;
    end else if (advance) begin
      if (pairJ == RuleW'(NumRules - 1)) begin
        pairI <= pairI + RuleW'(1);
        pairJ <= pairI + RuleW'(2);
      end else begin
        pairJ <= pairJ + RuleW'(1);
      end
    end
  end

  // Scan high to low so the lowest-index match is the one left standing
  always_comb begin
    hit    = 1'b0;
    hitIdx = SlvIdxW'(DefaultIdx);
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (actEn[r] && (dec_addr_i >= actBase[r]) && (dec_addr_i < actEnd[r])) begin
        hit    = 1'b1;
        hitIdx = actIdx[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o <= 1'b0;
      dec_idx_o   <= '0;
      dec_err_o   <= 1'b0;
    end else begin
      dec_valid_o <= dec_valid_i;
      if (dec_valid_i) begin
        dec_idx_o <= hitIdx;
        dec_err_o <= !hit;
      end else begin
        dec_err_o <= 1'b0;
      end
    end
  end

`ifdef CARFIELD_REGION_MAP_MISS_LOG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      missCnt  <= '0;
      missAddr <= '0;
    end else begin
      if (wrAcc && (reg_addr_i == AddrMissCnt)) begin
        missCnt <= '0;
      end else if (dec_valid_i && !hit && (missCnt != '1)) begin
        missCnt <= missCnt + 32'd1;
      end
      if (dec_valid_i && !hit) begin
        missAddr <= dec_addr_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_carfield_region_map_ctrl.sv
// tb/tb_carfield_region_map_ctrl.sv - scoreboard bench for carfield_region_map_ctrl
module tb_carfield_region_map_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk;
  } regExp_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       err;
  } decExp_t;

  logic        clk, rst_ni;
  logic        reg_valid_i, reg_write_i;
  logic [8:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_rvalid_o, reg_error_o;
  logic [31:0] reg_rdata_o;
  logic        dec_valid_i;
  logic [47:0] dec_addr_i;
  logic        dec_valid_o, dec_err_o, cfg_busy_o;
  logic [2:0]  dec_idx_o;

  int nVec = 0;
  int nMis = 0;
  int busyCycles = 0;

  regExp_t regQ[$];
  decExp_t decQ[$];
  regExp_t re;
  decExp_t de;

  carfield_region_map_ctrl #(
    .NumRules  (8),
    .NumSlv    (7),
    .AddrWidth (48),
    .DefaultIdx(5),
    .InitStart ({{7{48'h0}}, 48'h0000_7800_0000}),
    .InitEnd   ({{7{48'h0}}, 48'h0000_7820_0000}),
    .InitIdx   ('0),
    .InitEn    (8'h01)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_valid_i (reg_valid_i),
    .reg_write_i (reg_write_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_error_o (reg_error_o),
    .dec_valid_i (dec_valid_i),
    .dec_addr_i  (dec_addr_i),
    .dec_valid_o (dec_valid_o),
    .dec_idx_o   (dec_idx_o),
    .dec_err_o   (dec_err_o),
    .cfg_busy_o  (cfg_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (cfg_busy_o) busyCycles++;
      if (reg_rvalid_o) begin
        if (regQ.size() == 0) begin
          checkVal("reg_rsp_expected", 64'(regQ.size()), 64'd1);
        end else begin
          re = regQ.pop_front();
          checkVal("reg_error", 64'(reg_error_o), 64'(re.err));
          if (re.chk) checkVal("reg_rdata", 64'(reg_rdata_o), 64'(re.data));
        end
      end
      if (dec_valid_o) begin
        if (decQ.size() == 0) begin
          checkVal("dec_rsp_expected", 64'(decQ.size()), 64'd1);
        end else begin
          de = decQ.pop_front();
          checkVal("dec_err", 64'(dec_err_o), 64'(de.err));
          checkVal("dec_idx", 64'(dec_idx_o), 64'(de.idx));
        end
      end
    end
  end

  task automatic regAcc(input logic wr, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic expErr, input logic chk, input logic [31:0] expData);
    regExp_t e;
    @(posedge clk); #1;
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    e.data = expData;
    e.err  = expErr;
    e.chk  = chk;
    regQ.push_back(e);
    @(posedge clk); #1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  task automatic regWr(input logic [8:0] addr, input logic [31:0] wdata, input logic expErr);
    regAcc(1'b1, addr, wdata, expErr, 1'b0, 32'h0);
  endtask

  task automatic regRd(input logic [8:0] addr, input logic [31:0] expData, input logic expErr);
    regAcc(1'b0, addr, 32'h0, expErr, !expErr, expData);
  endtask

  task automatic pushDec(input logic [47:0] addr, input logic [2:0] expIdx, input logic expErr);
    decExp_t e;
    dec_valid_i = 1'b1;
    dec_addr_i  = addr;
    e.idx = expIdx;
    e.err = expErr;
    decQ.push_back(e);
  endtask

  task automatic decReq(input logic [47:0] addr, input logic [2:0] expIdx, input logic expErr);
    @(posedge clk); #1;
    pushDec(addr, expIdx, expErr);
    @(posedge clk); #1;
    dec_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cfg_busy_o && k < 100);
    checkVal("busy_timeout", 64'(cfg_busy_o), 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (regQ.size() != 0 || decQ.size() != 0); k++) @(negedge clk);
  endtask

  logic [47:0] burstAddr [4];
  logic [2:0]  burstIdx  [4];
  logic        burstErr  [4];

  initial begin
    burstAddr[0] = 48'h0000_781F_FFFF; burstIdx[0] = 3'd0; burstErr[0] = 1'b0;
    burstAddr[1] = 48'h0000_7820_0000; burstIdx[1] = 3'd5; burstErr[1] = 1'b1;
    burstAddr[2] = 48'h0000_7800_0000; burstIdx[2] = 3'd0; burstErr[2] = 1'b0;
    burstAddr[3] = 48'h0001_7800_0000; burstIdx[3] = 3'd5; burstErr[3] = 1'b1;

    rst_ni = 1'b0;
    reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    dec_valid_i = 1'b0; dec_addr_i = '0;
    repeat (3) @(negedge clk);
    checkVal("rst_reg_rvalid", 64'(reg_rvalid_o), 64'd0);
    checkVal("rst_reg_rdata",  64'(reg_rdata_o),  64'd0);
    checkVal("rst_reg_error",  64'(reg_error_o),  64'd0);
    checkVal("rst_dec_valid",  64'(dec_valid_o),  64'd0);
    checkVal("rst_dec_idx",    64'(dec_idx_o),    64'd0);
    checkVal("rst_dec_err",    64'(dec_err_o),    64'd0);
    checkVal("rst_busy",       64'(cfg_busy_o),   64'd0);
    rst_ni = 1'b1;

    regRd(9'h000, 32'h7800_0000, 1'b0);
    regRd(9'h008, 32'h7820_0000, 1'b0);
    regRd(9'h00C, 32'h8000_0000, 1'b0);
    regRd(9'h104, 32'h0, 1'b0);
    regRd(9'h100, 32'h0, 1'b0);

    decReq(48'h0000_7800_0010, 3'd0, 1'b0);
    decReq(48'h0000_7820_0000, 3'd5, 1'b1);
    decReq(48'h0000_77FF_FFFF, 3'd5, 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      pushDec(burstAddr[k], burstIdx[k], burstErr[k]);
      @(posedge clk); #1;
    end
    dec_valid_i = 1'b0;

    regWr(9'h054, 32'hFFFF_FFFF, 1'b0);
    regRd(9'h054, 32'h0000_FFFF, 1'b0);
    regWr(9'h05C, 32'h7FFF_FF00, 1'b0);
    regRd(9'h05C, 32'h00FF_FF00, 1'b0);
    regRd(9'h180, 32'h0, 1'b1);
    regRd(9'h002, 32'h0, 1'b1);
    regWr(9'h104, 32'h1, 1'b1);

    regWr(9'h010, 32'h6000_0000, 1'b0);
    regWr(9'h014, 32'h0, 1'b0);
    regWr(9'h018, 32'h6080_0000, 1'b0);
    regWr(9'h01C, 32'h8000_0002, 1'b0);
    busyCycles = 0;
    regWr(9'h100, 32'h1, 1'b0);
    decReq(48'h0000_6000_0004, 3'd5, 1'b1);
    regWr(9'h030, 32'h1234, 1'b1);
    regRd(9'h104, 32'h1, 1'b0);
    waitIdle();
    pushDec(48'h0000_6000_0004, 3'd5, 1'b1);
    @(posedge clk); #1;
    pushDec(48'h0000_6000_0004, 3'd2, 1'b0);
    @(posedge clk); #1;
    dec_valid_i = 1'b0;
    checkVal("busy_cycles", 64'(busyCycles), 64'd28);
    regRd(9'h104, 32'h0, 1'b0);

    regWr(9'h020, 32'h7810_0000, 1'b0);
    regWr(9'h024, 32'h0, 1'b0);
    regWr(9'h028, 32'h7830_0000, 1'b0);
    regWr(9'h02C, 32'h8000_0001, 1'b0);
    regWr(9'h100, 32'h1, 1'b0);
    waitIdle();
    regRd(9'h104, 32'h0000_2002, 1'b0);
    decReq(48'h0000_7825_0000, 3'd5, 1'b1);
    decReq(48'h0000_6000_0004, 3'd2, 1'b0);
    decReq(48'h0000_7815_0000, 3'd0, 1'b0);

    regWr(9'h02C, 32'h0000_0001, 1'b0);
    regWr(9'h030, 32'h0000_1000, 1'b0);
    regWr(9'h038, 32'h0000_1000, 1'b0);
    regWr(9'h03C, 32'h8000_0003, 1'b0);
    regWr(9'h100, 32'h1, 1'b0);
    waitIdle();
    regRd(9'h104, 32'h0000_3004, 1'b0);
    regWr(9'h03C, 32'h8000_0009, 1'b1);
    regWr(9'h03C, 32'h8000_0007, 1'b1);
    regRd(9'h03C, 32'h8000_0003, 1'b0);
    regWr(9'h03C, 32'h8000_0006, 1'b0);
    regRd(9'h03C, 32'h8000_0006, 1'b0);
    decReq(48'h0000_0000_1000, 3'd5, 1'b1);

`ifdef CARFIELD_REGION_MAP_MISS_LOG_EN
    regWr(9'h108, 32'hDEAD, 1'b0);
    decReq(48'h0000_0000_0010, 3'd5, 1'b1);
    decReq(48'h0000_9000_0000, 3'd5, 1'b1);
    decReq(48'h0001_2345_6780, 3'd5, 1'b1);
    regRd(9'h108, 32'd3, 1'b0);
    regRd(9'h10C, 32'h2345_6780, 1'b0);
    regRd(9'h110, 32'h1, 1'b0);
    regWr(9'h10C, 32'h0, 1'b1);
`else
    regRd(9'h108, 32'h0, 1'b1);
    regWr(9'h108, 32'h0, 1'b1);
    regRd(9'h10C, 32'h0, 1'b1);
`endif

    regWr(9'h100, 32'h2, 1'b0);
    regRd(9'h104, 32'h0000_300C, 1'b0);
    regRd(9'h100, 32'h2, 1'b0);
    regWr(9'h000, 32'h1234, 1'b1);
    regRd(9'h000, 32'h7800_0000, 1'b0);
    regWr(9'h100, 32'h1, 1'b1);
    regRd(9'h104, 32'h0000_300C, 1'b0);

    drain();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    regRd(9'h104, 32'h0, 1'b0);
    regRd(9'h010, 32'h0, 1'b0);
    regWr(9'h010, 32'h5000_0000, 1'b0);
    regWr(9'h018, 32'h5010_0000, 1'b0);
    regWr(9'h01C, 32'h8000_0004, 1'b0);
    regWr(9'h100, 32'h1, 1'b0);
    repeat (5) @(negedge clk);
    checkVal("busy_mid_check", 64'(cfg_busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    checkVal("busy_async_rst", 64'(cfg_busy_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    decReq(48'h0000_5000_0000, 3'd5, 1'b1);
    decReq(48'h0000_7800_0010, 3'd0, 1'b0);
    regRd(9'h01C, 32'h0, 1'b0);
    regRd(9'h00C, 32'h8000_0000, 1'b0);
    regRd(9'h104, 32'h0, 1'b0);

    drain();
    checkVal("reg_q_drain", 64'(regQ.size()), 64'd0);
    checkVal("dec_q_drain", 64'(decQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
